// File: rtl/fb_pkg.sv
// Shared word geometry, address type and packer FSM states for the 1-bpp framebuffer feeder.
package fb_pkg;

  localparam int FB_WORD_W         = 32;
  localparam int FB_WORDS_PER_LINE = 20;
  localparam int FB_LINES          = 480;
  localparam int FB_WORDS          = FB_WORDS_PER_LINE * FB_LINES;

  typedef logic [14:0] fb_addr_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PACK = 1'b1
  } pack_state_t;

endpackage

// File: rtl/fb_wr_skid.sv
// Single-entry framebuffer write register: a load shows on wr_valid_o the next cycle.
// Holds addr/data while wr_valid_o & !wr_ready_i. The caller must not load while a write is stalled.
module fb_wr_skid
  import fb_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load_i,
  input  logic [ADDR_W-1:0]    load_addr_i,
  input  logic [FB_WORD_W-1:0] load_data_i,
  input  logic                 wr_ready_i,
  output logic                 wr_valid_o,
  output logic [ADDR_W-1:0]    wr_addr_o,
  output logic [FB_WORD_W-1:0] wr_data_o
);

  logic                 valid_q, valid_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [FB_WORD_W-1:0] data_q, data_d;

  // A load in the handshake cycle wins, giving back-to-back words with no bubble.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      addr_d  = load_addr_i;
      data_d  = load_data_i;
    end else if (valid_q && wr_ready_i) begin
      valid_d = 1'b0;
      addr_d  = '0;
      data_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign wr_valid_o = valid_q;
  assign wr_addr_o  = addr_q;
  assign wr_data_o  = data_q;

endmodule

// File: rtl/fb_pixel_packer.sv
// Packs a raster 1-bpp pixel stream into 32-bit framebuffer word writes; wr_valid rises 1 cycle after the 32nd pixel accept.
// in_ready drops only when a word completes while the previous write is still stalled; FB_PACK_STATS_EN adds frame/error counters.
module fb_pixel_packer
  import fb_pkg::*;
#(
  parameter int WORDS_PER_LINE = FB_WORDS_PER_LINE,
  parameter int LINES          = FB_LINES,
  parameter int ADDR_W         = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_pixel,
  input  logic                 in_sof,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [FB_WORD_W-1:0] wr_data,
  output logic                 frame_done,
  output logic                 sof_err
`ifdef FB_PACK_STATS_EN
  ,
  output logic [15:0]          frame_cnt,
  output logic [7:0]           err_cnt
`endif
);

  localparam int                FRAME_WORDS = WORDS_PER_LINE * LINES;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(FRAME_WORDS - 1);

  pack_state_t          state_q, state_d;
  logic [4:0]           bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0]    word_cnt_q, word_cnt_d;
  logic [FB_WORD_W-1:0] acc_q, acc_d;
  logic                 sof_err_q, sof_err_d;
  logic                 frame_done_q, frame_done_d;

  logic                 accept;
  logic                 load;
  logic [FB_WORD_W-1:0] first_word;
  logic [FB_WORD_W-1:0] merged_word;

  assign in_ready    = !((state_q == PACK) && (bit_cnt_q == 5'd31) && wr_valid && !wr_ready);
  assign accept      = in_valid && in_ready;
  assign first_word  = {{(FB_WORD_W-1){1'b0}}, in_pixel};
  // Leftmost pixel of a word lands in bit 0.
  assign merged_word = acc_q | (first_word << bit_cnt_q);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    acc_d      = acc_q;
    sof_err_d  = 1'b0;
    load       = 1'b0;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (in_sof) begin
            state_d    = PACK;
            acc_d      = first_word;
            bit_cnt_d  = 5'd1;
            word_cnt_d = '0;
          end
        end
        PACK: begin
          if (in_sof && ((bit_cnt_q != 5'd0) || (word_cnt_q != '0))) begin
            // Restart the frame; a word already in the write register still goes out.
            sof_err_d  = 1'b1;
            acc_d      = first_word;
            bit_cnt_d  = 5'd1;
            word_cnt_d = '0;
          end else if (bit_cnt_q == 5'd31) begin
            load      = 1'b1;
            acc_d     = '0;
            bit_cnt_d = 5'd0;
            if (word_cnt_q == LAST_ADDR) begin
              word_cnt_d = '0;
              state_d    = IDLE;
            end else begin
              word_cnt_d = word_cnt_q + 1'b1;
            end
          end else begin
            acc_d     = merged_word;
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign frame_done_d = wr_valid && wr_ready && (wr_addr == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      acc_q        <= '0;
      sof_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      acc_q        <= acc_d;
      sof_err_q    <= sof_err_d;
      frame_done_q <= frame_done_d;
    end
  end

  fb_wr_skid #(
    .ADDR_W (ADDR_W)
  ) u_wr_skid (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_i      (load),
    .load_addr_i (word_cnt_q),
    .load_data_i (merged_word),
    .wr_ready_i  (wr_ready),
    .wr_valid_o  (wr_valid),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data)
  );

  assign sof_err    = sof_err_q;
  assign frame_done = frame_done_q;

`ifdef FB_PACK_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  err_cnt_q;

  // Frame count wraps; error count sticks at its maximum.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (frame_done_q) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (sof_err_q && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_fb_pixel_packer.sv
// Directed bench for fb_pixel_packer with a pixel-position reference model checked every cycle.
// The frame is shortened to 6 lines so full frames stay short; word geometry is unchanged.
`timescale 1ns/1ps
module tb_fb_pixel_packer;

  localparam int AW          = 15;
  localparam int NLINES      = 6;
  localparam int FRAME_WORDS = (640 / 32) * NLINES;
  localparam int FRAME_PIX   = FRAME_WORDS * 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_pixel = 1'b0;
  logic in_sof = 1'b0;
  logic wr_ready = 1'b1;
  logic in_ready, wr_valid, frame_done, sof_err;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
`ifdef FB_PACK_STATS_EN
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
`endif

  always #10 clk = ~clk;

  fb_pixel_packer #(
    .WORDS_PER_LINE (640 / 32),
    .LINES          (NLINES),
    .ADDR_W         (AW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .in_sof     (in_sof),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .sof_err    (sof_err)
`ifdef FB_PACK_STATS_EN
    ,
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt)
`endif
  );

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  hs_addr[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc = 0;

  bit          m_in_frame = 0;
  int          m_pos = 0;
  logic [31:0] m_cur = '0;
  bit          exp_fd = 0;
  bit          exp_se = 0;

  int          n_writes, n_fd, n_se, n_rdy_low, last_hs_cyc, fd_cyc, last_hs_addr;
  logic [31:0] last_hs_data, first_hs_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: pixel p of the frame belongs to word p/32, bit p%32.
  task automatic model_accept(input logic pix, input logic sof);
    if (!m_in_frame && !sof) return;
    if (sof && (!m_in_frame || m_pos != 0)) begin
      if (m_in_frame) exp_se = 1;
      m_in_frame = 1;
      m_pos      = 0;
      m_cur      = '0;
    end
    m_cur[m_pos % 32] = pix;
    if (m_pos % 32 == 31) begin
      exp_q.push_back('{m_pos / 32, m_cur});
      m_cur = '0;
      if (m_pos / 32 == FRAME_WORDS - 1) m_in_frame = 0;
    end
    m_pos++;
  endtask

  always @(negedge clk) begin
    bit rdy_exp;
    cyc++;
    if (!reset_n) begin
      exp_q.delete();
      m_in_frame = 0;
      m_pos      = 0;
      m_cur      = '0;
      exp_fd     = 0;
      exp_se     = 0;
    end else begin
      rdy_exp = !(m_in_frame && (m_pos % 32 == 31) && (exp_q.size() != 0) && !wr_ready);
      chk("in_ready", in_ready, rdy_exp);
      chk("wr_valid", wr_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("wr_addr", wr_addr, exp_q[0].addr);
        chk("wr_data", wr_data, exp_q[0].data);
      end
      chk("frame_done", frame_done, exp_fd);
      chk("sof_err", sof_err, exp_se);
      if (frame_done) begin
        n_fd++;
        fd_cyc = cyc;
      end
      if (sof_err) n_se++;
      if (!in_ready) n_rdy_low++;
      exp_fd = 0;
      exp_se = 0;
      if (wr_valid && wr_ready) begin
        if (n_writes == 0) first_hs_data = wr_data;
        n_writes++;
        last_hs_cyc  = cyc;
        last_hs_addr = int'(wr_addr);
        last_hs_data = wr_data;
        hs_addr.push_back(int'(wr_addr));
        if (exp_q.size() != 0) begin
          if (exp_q[0].addr == FRAME_WORDS - 1) exp_fd = 1;
          void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) model_accept(in_pixel, in_sof);
    end
  end

  task automatic send(input logic pix, input logic sof);
    int t;
    in_valid = 1'b1;
    in_pixel = pix;
    in_sof   = sof;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 500) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: in_ready low for %0d cycles, required 1", t);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
  endtask

  task automatic clear_stats();
    n_writes     = 0;
    n_fd         = 0;
    n_se         = 0;
    n_rdy_low    = 0;
    last_hs_addr = -1;
    last_hs_data = '0;
    first_hs_data = '0;
    hs_addr.delete();
  endtask

  function automatic logic pat(input int p);
    return ((p * 5 + 3) % 7) < 3;
  endfunction

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog: simulation exceeded 60000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_a[4];
    exp_a = '{0, 1, 2, 0};
    clear_stats();

    // Reset values
    idle(3);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_sof_err", sof_err, 0);
    @(posedge clk);
    #1;

    // Pixels without sof in IDLE are dropped
    clear_stats();
    for (int p = 0; p < 10; p++) send(1'b1, 1'b0);
    idle(3);
    chk("idle_no_writes", n_writes, 0);

    // Full frame of alternating pixels at full rate
    clear_stats();
    for (int p = 0; p < FRAME_PIX; p++) send((p % 2) == 0, p == 0);
    idle(4);
    chk("f1_writes", n_writes, FRAME_WORDS);
    chk("f1_frame_done_cnt", n_fd, 1);
    chk("f1_in_ready_drops", n_rdy_low, 0);
    chk("f1_last_addr", last_hs_addr, FRAME_WORDS - 1);
    chk("f1_last_data", last_hs_data, 32'h5555_5555);
    chk("f1_frame_done_lat", fd_cyc - last_hs_cyc, 1);

    // Single set pixel lands in bit 0; wr_valid one cycle after the 32nd accept
    clear_stats();
    for (int p = 0; p < 32; p++) send(p == 0, p == 0);
    @(negedge clk);
    chk("t3_wr_valid", wr_valid, 1);
    chk("t3_wr_addr", wr_addr, 0);
    chk("t3_wr_data", wr_data, 32'h0000_0001);
    @(posedge clk);
    #1;
    idle(2);
    do_reset();

    // Write stall for 40 cycles after word 0
    clear_stats();
    wr_ready = 1'b0;
    fork
      begin
        for (int p = 0; p < 96; p++) send(pat(p), p == 0);
      end
      begin
        int t;
        t = 0;
        while (!wr_valid && t < 200) begin
          @(negedge clk);
          t++;
        end
        repeat (40) @(posedge clk);
        #1;
        wr_ready = 1'b1;
      end
    join
    idle(4);
    chk("t4_writes", n_writes, 3);
    chk("t4_last_addr", last_hs_addr, 2);
    chk("t4_word0_data", first_hs_data, 32'h264C_9932);
    chk("t4_stalled", n_rdy_low > 0, 1);

    // sof at pixel 100 restarts the frame
    do_reset();
    clear_stats();
    for (int p = 0; p < 100; p++) send((p % 3) == 0, p == 0);
    send(1'b1, 1'b1);
    for (int p = 0; p < 31; p++) send(1'b0, 1'b0);
    idle(4);
    chk("t5_sof_err_cnt", n_se, 1);
    chk("t5_writes", n_writes, 4);
    for (int i = 0; i < hs_addr.size() && i < 4; i++)
      chk($sformatf("t5_addr%0d", i), hs_addr[i], exp_a[i]);
    chk("t5_restart_data", last_hs_data, 32'h0000_0001);

    // Reset mid-frame with a stalled write pending
    do_reset();
    clear_stats();
    wr_ready = 1'b0;
    for (int p = 0; p < 40; p++) send(p % 2, p == 0);
    @(negedge clk);
    chk("t6_pending", wr_valid, 1);
    @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    chk("t6_wr_valid", wr_valid, 0);
    chk("t6_wr_addr", wr_addr, 0);
    chk("t6_wr_data", wr_data, 0);
    chk("t6_in_ready", in_ready, 1);
    chk("t6_sof_err", sof_err, 0);
    @(posedge clk);
    #1;
    wr_ready = 1'b1;
    idle(2);

`ifdef FB_PACK_STATS_EN
    do_reset();
    clear_stats();
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < FRAME_PIX; p++) send((p % 2) == 0, p == 0);
    idle(4);
    chk("st_frame_cnt", frame_cnt, 2);
    for (int i = 0; i < 301; i++) send(i % 2, 1'b1);
    idle(4);
    chk("st_sof_err_pulses", n_se, 300);
    chk("st_err_cnt", err_cnt, 255);
    chk("st_frame_cnt_kept", frame_cnt, 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fb_pixel_packer.md
Name: fb_pixel_packer

Overview:
- Upstream feeder for the 1-bpp VGA framebuffer RAM: accepts a raster-order stream of 1-bit pixels (640x480) and packs 32 pixels per 32-bit word.
- Issues one word write per 32 pixels at the word address the display scanout reads, so a rendered frame lands directly in the framebuffer.
- Sits between a pixel source (renderer/DMA) and the framebuffer write-port arbiter.

Parameters:
- WORDS_PER_LINE, 20, 32-pixel words per scanline (640/32)
- LINES, 480, active scanlines per frame
- ADDR_W, 15, framebuffer word-address width

Ports:
- clk  in  1  system clock (50 MHz)
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  pixel-stream valid
- in_ready  out  1  pixel-stream ready
- in_pixel  in  1  pixel value (1 = white)
- in_sof  in  1  start of frame; qualifies the first pixel of a frame
- wr_valid  out  1  framebuffer write request
- wr_ready  in  1  write accepted by arbiter/RAM this cycle
- wr_addr  out  ADDR_W  word address
- wr_data  out  32  packed pixels
- frame_done  out  1  1-cycle pulse when a frame's last word handshakes
- sof_err  out  1  1-cycle pulse when in_sof arrives mid-frame

Behaviour:
- Clock and reset: clk; reset_n is synchronous and active-low, sampled on posedge clk.
- Reset values: in_ready=1, wr_valid=0, wr_addr=0, wr_data=0, frame_done=0, sof_err=0, FSM=IDLE, bit_cnt=0, word_cnt=0, accumulator=0. Reset mid-frame drops the partial word and any pending write.
- Accept: a pixel is accepted when in_valid & in_ready.
- Packing: pixel k of a word (k=0..31, left to right) goes to bit k, i.e. column[4:0]. Address = line*WORDS_PER_LINE + word_in_line, which equals the running word_cnt. Frame size = WORDS_PER_LINE*LINES = 9600 words (0..9599).
- FSM IDLE:
  - in_ready=1; accepted pixels without in_sof are discarded.
  - An accepted pixel with in_sof becomes bit 0 of word 0 -> PACK.
- FSM PACK:
  - Each accepted pixel shifts into the accumulator and increments bit_cnt.
  - On the 32nd pixel (bit_cnt=31), the completed word moves to the output register the following cycle: wr_valid=1, wr_addr=word_cnt, wr_data=word. Latency is 1 cycle from accept to wr_valid.
  - bit_cnt wraps to 0 and word_cnt increments.
  - When the completed word is 9599 -> IDLE.
- Output register: holds wr_addr/wr_data stable while wr_valid & !wr_ready; clears on handshake unless refilled in the same cycle.
- Backpressure: in_ready=0 only when in PACK, bit_cnt=31 and a write is pending (wr_valid & !wr_ready). Full throughput of 1 pixel/cycle is required when wr_ready is held high.
- Mid-frame in_sof (accepted in PACK with bit_cnt!=0 or word_cnt!=0):
  - sof_err pulses the next cycle and the partial accumulator is discarded.
  - word_cnt=0, and this pixel becomes bit 0 of word 0.
  - An already-pending output word is still delivered.
- frame_done pulses 1 cycle after the handshake of address 9599.
- Simultaneous wr handshake and new word completion: the new word loads with no bubble.
- Counter widths: bit_cnt is 5 bits; word_cnt is ADDR_W bits and never exceeds 9599.

Optional Feature:
- FB_PACK_STATS_EN defined:
  - Adds outputs frame_cnt[15:0] (increments on frame_done, wraps at 65535) and err_cnt[7:0] (increments on sof_err, saturates at 255).
  - Both reset to 0.
- Undefined: these ports and counters do not exist.

Decomposition:
- Package fb_pkg holds FB_WORD_W=32, FB_WORDS_PER_LINE=20, FB_LINES=480, FB_WORDS=9600, and typedef fb_addr_t (logic [14:0]).
- Package also holds the FSM enum pack_state_t {IDLE, PACK}.
- One sub-module: fb_wr_skid, the single-entry output register with valid/ready hold.

Test Plan:
- Frame of alternating pixels (1,0,1,0...), wr_ready=1 -> 9600 writes at addresses 0..9599, each with data 0x55555555; frame_done pulses once, 1 cycle after addr 9599; no in_ready drop.
- 32 pixels with only pixel 0 = 1, after sof -> wr_data=0x00000001 at addr 0; wr_valid rises 1 cycle after the 32nd accept.
- wr_ready=0 for 40 cycles after the first word -> addr 0 data held stable; in_ready falls at bit_cnt=31 of word 1; no pixel loss; addr 1 is written after release.
- in_sof at pixel 100 of a frame -> sof_err pulse; words 0..2 written once; partial word 3 discarded; next write is addr 0.
- Pixels without sof in IDLE -> no writes. reset_n low mid-frame -> all outputs return to reset values next cycle.
- With FB_PACK_STATS_EN: two full frames -> frame_cnt=2; 300 mid-frame sofs -> err_cnt=255.
